// File: rtl/skid_buffer.sv
// Two-entry skid buffer: valid/ready on both sides, in_ready driven only from registered state.
// The main register feeds out_data; the skid register holds one overflow word while stalled.
module skid_buffer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        skid_d    = skid_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        count     = 2'd0;
        unique case (state_q)
            StEmpty: begin
                in_ready = 1'b1;
                count    = 2'd0;
                if (in_xfer) begin
                    state_d = StBusy;
                    main_d  = in_data;
                end
            end
            StBusy: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                count     = 2'd1;
                if (in_xfer && out_xfer) begin
                    main_d = in_data;
                end else if (in_xfer) begin
                    // Downstream stalled: park the new word, keep main stable.
                    state_d = StFull;
                    skid_d  = in_data;
                end else if (out_xfer) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                out_valid = 1'b1;
                count     = 2'd2;
                if (out_xfer) begin
                    state_d = StBusy;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    assign out_data = main_q;

endmodule

// File: tb/tb_skid_buffer.sv
// Directed self-checking bench for skid_buffer; one task per scenario, inline comparisons.
module tb_skid_buffer;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    int total;
    int bad;

    skid_buffer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle; inputs are changed only after this returns.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (out_data !== 4'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 4'hA; out_ready = 1'b1;
        step();
        in_valid = 1'b0; in_data = 4'h6;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", out_valid); end
        total++; if (out_data !== 4'hA) begin bad++; $display("FAIL single_data got=%h want=a", out_data); end
        total++; if (count !== 2'd1) begin bad++; $display("FAIL single_count got=%0d want=1", count); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%b want=0", out_valid); end
        total++; if (count !== 2'd0) begin bad++; $display("FAIL single_count0 got=%0d want=0", count); end
    endtask

    task automatic test_hold_busy();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 4'hC;
        step();
        in_valid = 1'b0; in_data = 4'h1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (out_data !== 4'hC || out_valid !== 1'b1) begin
                bad++; $display("FAIL hold_busy cyc=%0d got=%b/%h want=1/c", i, out_valid, out_data);
            end
            total++; if (count !== 2'd1) begin bad++; $display("FAIL hold_busy_count got=%0d want=1", count); end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (count !== 2'd0) begin bad++; $display("FAIL hold_busy_drain got=%0d want=0", count); end
    endtask

    task automatic test_fill();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h5;
        step();
        total++; if (count !== 2'd1) begin bad++; $display("FAIL fill_count1 got=%0d want=1", count); end
        in_data = 4'hF;
        step();
        total++; if (count !== 2'd2) begin bad++; $display("FAIL fill_count2 got=%0d want=2", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b want=0", in_ready); end
        total++; if (out_data !== 4'h5) begin bad++; $display("FAIL fill_out_data got=%h want=5", out_data); end
        in_data = 4'h3;
        step();
        total++; if (count !== 2'd2) begin bad++; $display("FAIL fill_third_count got=%0d want=2", count); end
        total++; if (out_data !== 4'h5) begin bad++; $display("FAIL fill_stable got=%h want=5", out_data); end
        in_valid = 1'b0;
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        total++; if (out_valid !== 1'b1 || out_data !== 4'h5) begin
            bad++; $display("FAIL drain_first got=%b/%h want=1/5", out_valid, out_data);
        end
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 4'hF) begin
            bad++; $display("FAIL drain_second got=%b/%h want=1/f", out_valid, out_data);
        end
        total++; if (count !== 2'd1 || in_ready !== 1'b1) begin
            bad++; $display("FAIL drain_busy got=%0d/%b want=1/1", count, in_ready);
        end
        step();
        total++; if (out_valid !== 1'b0 || count !== 2'd0) begin
            bad++; $display("FAIL drain_empty got=%b/%0d want=0/0", out_valid, count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] v;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            v = 4'(i);
            in_data = v;
            step();
            total++; if (out_valid !== 1'b1 || out_data !== v) begin
                bad++; $display("FAIL b2b_data i=%0d got=%b/%h want=1/%h", i, out_valid, out_data, v);
            end
            total++; if (count !== 2'd1) begin bad++; $display("FAIL b2b_count i=%0d got=%0d want=1", i, count); end
        end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0 || count !== 2'd0) begin
            bad++; $display("FAIL b2b_end got=%b/%0d want=0/0", out_valid, count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h9;
        step();
        in_data = 4'hB;
        step();
        total++; if (count !== 2'd2) begin bad++; $display("FAIL rstmid_full got=%0d want=2", count); end
        rst = 1'b1; out_ready = 1'b1; in_data = 4'h7;
        step();
        rst = 1'b0; in_valid = 1'b0;
        total++; if (count !== 2'd0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL rstmid_cleared got=%0d/%b want=0/0", count, out_valid);
        end
        total++; if (out_data !== 4'h0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_data got=%h/%b want=0/1", out_data, in_ready);
        end
        step();
        total++; if (count !== 2'd0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL rstmid_after got=%0d/%b want=0/0", count, out_valid);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_hold_busy();
        test_fill();
        test_drain();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/skid_buffer.md
SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, data bus width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  upstream asserts when in_data is valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept in_data this cycle.
REQ-006 SHALL have port: in_data  input  WIDTH  upstream payload.
REQ-007 SHALL have port: out_valid  output  1  out_data is valid.
REQ-008 SHALL have port: out_ready  input  1  downstream (enabled D flip-flop stage) accepts out_data this cycle.
REQ-009 SHALL have port: out_data  output  WIDTH  payload to downstream.
REQ-010 SHALL have port: count  output  2  entries held (0, 1 or 2).

Function
REQ-011 SHALL accept input only on a posedge where in_valid=1 and in_ready=1 (in-transfer).
REQ-012 SHALL deliver output only on a posedge where out_valid=1 and out_ready=1 (out-transfer).
REQ-013 SHALL hold two registers: main (drives out_data) and skid (overflow entry).
REQ-014 SHALL implement states EMPTY (count=0), BUSY (count=1), FULL (count=2).
REQ-015 SHALL drive out_valid=1 in BUSY and FULL, 0 in EMPTY.
REQ-016 SHALL drive in_ready=1 in EMPTY and BUSY, 0 in FULL; in_ready is purely registered state, with no combinational path from out_ready.
REQ-017 SHALL transition EMPTY + in-transfer -> BUSY, main<=in_data.
REQ-018 SHALL transition BUSY + in-transfer + out-transfer -> BUSY, main<=in_data.
REQ-019 SHALL transition BUSY + in-transfer, no out-transfer -> FULL, skid<=in_data, main unchanged.
REQ-020 SHALL transition BUSY + out-transfer, no in-transfer -> EMPTY.
REQ-021 SHALL transition FULL + out-transfer -> BUSY, main<=skid.
REQ-022 SHALL stay in FULL with main and skid unchanged when out_ready=0, regardless of in_valid.
REQ-023 SHALL hold all state, when neither transfer occurs.
REQ-024 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-025 SHALL have a latency of 1 cycle from in-transfer to out_valid when EMPTY.
REQ-026 SHALL sustain 1 transfer/cycle when in_valid=1 and out_ready=1 continuously.
REQ-027 SHALL preserve order; no word is dropped or duplicated.
REQ-028 SHALL ignore in_data when no in-transfer occurs; out_data is don't-care in EMPTY but is never X after reset.
REQ-029 SHALL keep count equal to the number of in-transfers minus out-transfers since reset, never exceeding 2.

Reset
REQ-030 SHALL, on a posedge with rst=1, set state EMPTY, main=0, skid=0, count=0, out_valid=0.
REQ-031 SHALL set in_ready=1 from the first cycle after reset.
REQ-032 SHALL give rst priority over every transfer on the same edge; any in-transfer or out-transfer on that edge is discarded.
REQ-033 SHALL, on reset asserted mid-operation (BUSY or FULL), discard all held entries.

Verification
REQ-034 SHALL pass this directed scenario: rst=1 for 2 cycles, then release -> out_valid=0, in_ready=1, count=0, out_data=4'h0.
REQ-035 SHALL pass this directed scenario: EMPTY, in_valid=1 in_data=4'hA for 1 cycle, out_ready=1 -> next cycle out_valid=1 out_data=4'hA; following cycle out_valid=0.
REQ-036 SHALL pass this directed scenario: out_ready=0, push 4'h5 then 4'hF -> count=2, in_ready=0, out_data=4'h5; third push 4'h3 is not accepted.
REQ-037 SHALL pass this directed scenario: from FULL (4'h5,4'hF), out_ready=1 for 2 cycles -> out_data sequence 4'h5, 4'hF, then out_valid=0, count=0.
REQ-038 SHALL pass this directed scenario: in_valid=1, out_ready=1 continuously, data 1..8 -> outputs 1..8 in order on consecutive cycles, count stays 1.
REQ-039 SHALL pass this directed scenario: FULL, then rst=1 together with out_ready=1 -> next cycle count=0, out_valid=0, nothing delivered.
